iir_out_quant: RTL
==================

# iir_out_quant

Output requantization stage placed directly downstream of the cascaded-SOS IIR. It takes the IIR's wide fixed-point result (WII.WFI) on each CE sample strobe, rounds it to the system output format (WOI.WFO), saturates on range overflow, and buffers results in a small first-word-fall-through FIFO with a valid/ready interface. It also collects the per-section adder overflow flags and its own saturation events into sticky status bits for software.

## Interface
- WII, 23, integer bits of input `din` (matches IIR WIO)
- WFI, 44, fraction bits of input `din` (matches IIR WFO)
- WOI, 5, integer bits of output `dout`; constraint WOI ≤ WII
- WOF, 11, fraction bits of output `dout`; constraint WOF < WFI
- DEPTH, 4, FIFO entries, power of two, ≥ 2
- NUMBER, 4, number of SOS sections whose overflow flags are monitored
- CLK  in  1  clock; all state updates on the rising edge
- RST  in  1  synchronous, active-high reset
- CE  in  1  sample strobe; `din` is valid when high
- din  in  WII+WFI  signed two's-complement IIR output
- OVF_f0, OVF_f1, OVF_b0, OVF_b1  in  NUMBER each  per-section adder overflow flags from the IIR
- clr_sticky  in  1  single-cycle clear of all sticky status bits
- dout  out  WOI+WOF  signed requantized sample at the FIFO head
- dout_valid  out  1  FIFO not empty
- dout_ready  in  1  consumer accepts the head entry
- level  out  $clog2(DEPTH)+1  current FIFO occupancy
- sat_sticky  out  1  set by any saturation event
- ovf_sticky  out  NUMBER  bit i set by any of OVF_*[i]
- drop_cnt  out  8  count of samples lost to a full FIFO, saturates at 255

## Operation
- Stage 1 (round), on a cycle with CE=1: compute r = din + 2^(WFI−WOF−1) at WII+WFI+1 bits, sign-extended. Keep y = r[WII+WFI : WFI−WOF], WII+WOF+1 bits. Midpoints therefore round toward +∞. Register y and v1=CE.
- Stage 2 (saturate): if y > 2^(WOI+WOF−1)−1, output 0x7FF…F. If y < −2^(WOI+WOF−1), output 0x800…0. Otherwise output y[WOI+WOF−1:0]. Register the result, v2=v1, and s2 = saturated & v1.
- Push: when v2=1. Accepted if level<DEPTH, or if level==DEPTH and a pop happens in the same cycle; in that case level is unchanged.
- Otherwise the sample is discarded and drop_cnt increments, saturating at 255.
- Pop: dout_valid & dout_ready. dout always shows the oldest entry. dout holds its value while dout_valid=1 and dout_ready=0.
- Sticky bits:
  - sat_sticky sets when s2=1.
  - ovf_sticky[i] sets on any cycle where OVF_f0[i]|OVF_f1[i]|OVF_b0[i]|OVF_b1[i] is high (sampled every cycle, independent of CE).
  - clr_sticky clears sat_sticky, ovf_sticky and drop_cnt. A set event in the same cycle wins over the clear.
- Reset: clears v1, v2, FIFO pointers, level, and all sticky/count state. All outputs read 0 the cycle after RST, including dout = 0 and dout_valid = 0. Samples in flight at reset are lost and are not counted as drops.

## Timing
- Latency: CE at edge n gives a push at edge n+2. If the FIFO was empty, dout_valid=1 and dout is valid after edge n+2 (2 cycles).
- Throughput: one sample per cycle (CE may stay high continuously).
- Pop takes effect at the edge where dout_valid & dout_ready are both high. The next entry appears after that edge.
- Pipeline stages have no back-pressure; overflow is handled only by dropping at FIFO entry.
- level, dout_valid, the sticky bits and drop_cnt are all registered and update at the same edge as the event that changes them.

## Test plan
- **Basic conversion:** reset, then din = 1.0 (0x1 << 44) with CE → dout = 0x0800, dout_valid high 2 cycles after CE, level = 1.
- **Rounding:**
  - din = +2^−12 → 0x0001.
  - din = −2^−12 → 0x0000.
  - din = −3·2^−12 → 0xFFFF (−2^−11).
  - din = 0.75·2^−11 → 0x0001.
- **Saturation:**
  - din = 20.0 → 0x7FFF and sat_sticky=1.
  - din = −16.0 → 0x8000 with sat_sticky unchanged.
  - din = −17.0 → 0x8000 and sat_sticky=1.
  - Pulse clr_sticky → sat_sticky=0.
- **Full FIFO:** DEPTH=4, dout_ready=0, six back-to-back CE samples 1..6 → level=4 and drop_cnt=2. Raise dout_ready → drains 1,2,3,4 in order, then dout_valid=0.
- **Push and pop when full:** keep the FIFO full with dout_ready=1 and CE continuous → level stays 4, drop_cnt stays 0, output sequence is in order with no gaps.
- **Overflow flags and mid-operation reset:**
  - Pulse OVF_b1[2] for one cycle → ovf_sticky = 4'b0100.
  - Assert RST with level=3 and a sample in flight → next cycle level=0, dout_valid=0, ovf_sticky=0, drop_cnt=0, and no push from the in-flight sample.

Source files
------------

// File: rtl/iir_out_quant_if.sv
// rtl/iir_out_quant_if.sv - sample input and requantized output stream of iir_out_quant
interface iir_out_quant_if #(
  parameter int DIN_W  = 67,
  parameter int DOUT_W = 16
);
  logic              CE;
  logic [DIN_W-1:0]  din;
  logic [DOUT_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;

  modport master (output CE, din, dout_ready, input dout, dout_valid);
  modport slave  (input CE, din, dout_ready, output dout, dout_valid);
endinterface

// File: rtl/iir_out_quant.sv
// rtl/iir_out_quant.sv - round/saturate IIR output into a FWFT FIFO with sticky status
module iir_out_quant #(
  parameter int WII    = 23,
  parameter int WFI    = 44,
  parameter int WOI    = 5,
  parameter int WOF    = 11,
  parameter int DEPTH  = 4,
  parameter int NUMBER = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  iir_out_quant_if.slave             bus,
  input  logic [NUMBER-1:0]          OVF_f0,
  input  logic [NUMBER-1:0]          OVF_f1,
  input  logic [NUMBER-1:0]          OVF_b0,
  input  logic [NUMBER-1:0]          OVF_b1,
  input  logic                       clr_sticky,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       sat_sticky,
  output logic [NUMBER-1:0]          ovf_sticky,
  output logic [7:0]                 drop_cnt
);
  localparam int WIN  = WII + WFI;
  localparam int SH   = WFI - WOF;
  localparam int WY   = WII + WOF + 1;
  localparam int WOUT = WOI + WOF;
  localparam int AW   = $clog2(DEPTH);
  localparam int LW   = AW + 1;

  localparam logic [WIN:0] HALF = {{(WIN-SH+1){1'b0}}, 1'b1, {(SH-1){1'b0}}};
  localparam logic signed [WY-1:0] MAXV = {{(WY-WOUT+1){1'b0}}, {(WOUT-1){1'b1}}};
  localparam logic signed [WY-1:0] MINV = {{(WY-WOUT+1){1'b1}}, {(WOUT-1){1'b0}}};

  logic [WIN:0]           rnd;
  logic signed [WY-1:0]   y_d, y_q;
  logic                   v1_q;
  logic [WOUT-1:0]        q2_d, q2_q;
  logic                   s2_d, s2_q, v2_q;

  logic [WOUT-1:0]        mem_q [DEPTH];
  logic [AW-1:0]          wr_q, rd_q;
  logic [LW-1:0]          level_d, level_q;
  logic                   pop, full, push_ok, drop;

  logic                   sat_d, sat_q;
  logic [NUMBER-1:0]      ovf_d, ovf_q;
  logic [7:0]             drop_d, drop_q;
  logic [7:0]             drop_base;

  // Adding half an output LSB before truncation makes midpoints round toward +inf.
  always_comb begin
    rnd = {bus.din[WIN-1], bus.din} + HALF;
    y_d = rnd[WIN:SH];
  end

  always_comb begin
    q2_d = y_q[WOUT-1:0];
    s2_d = 1'b0;
    if (y_q > MAXV) begin
      q2_d = {1'b0, {(WOUT-1){1'b1}}};
      s2_d = v1_q;
    end else if (y_q < MINV) begin
      q2_d = {1'b1, {(WOUT-1){1'b0}}};
      s2_d = v1_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      y_q  <= '0;
      v1_q <= 1'b0;
      q2_q <= '0;
      v2_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      y_q  <= y_d;
      v1_q <= bus.CE;
      q2_q <= q2_d;
      v2_q <= v1_q;
      s2_q <= s2_d;
    end
  end

  // A push into a full FIFO is still accepted when the head leaves in the same cycle.
  always_comb begin
    pop     = (level_q != '0) && bus.dout_ready;
    full    = (level_q == LW'(DEPTH));
    push_ok = v2_q && (!full || pop);
    drop    = v2_q && full && !pop;
    level_d = level_q + LW'(push_ok) - LW'(pop);
  end

  always_ff @(posedge CLK) begin
    if (push_ok) mem_q[wr_q] <= q2_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + AW'(1);
      if (pop)     rd_q <= rd_q + AW'(1);
      level_q <= level_d;
    end
  end

  // Set events are ORed in after the clear so they win over clr_sticky.
  always_comb begin
    sat_d     = (clr_sticky ? 1'b0 : sat_q) | s2_q;
    ovf_d     = (clr_sticky ? '0 : ovf_q) | (OVF_f0 | OVF_f1 | OVF_b0 | OVF_b1);
    drop_base = clr_sticky ? 8'd0 : drop_q;
    drop_d    = drop_base;
    if (drop && (drop_base != 8'hFF)) drop_d = drop_base + 8'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sat_q  <= 1'b0;
      ovf_q  <= '0;
      drop_q <= '0;
    end else begin
      sat_q  <= sat_d;
      ovf_q  <= ovf_d;
      drop_q <= drop_d;
    end
  end

  assign bus.dout       = (level_q != '0) ? mem_q[rd_q] : '0;
  assign bus.dout_valid = (level_q != '0);
  assign level          = level_q;
  assign sat_sticky     = sat_q;
  assign ovf_sticky     = ovf_q;
  assign drop_cnt       = drop_q;
endmodule
